bfly_in_buf: RTL and testbench

- Input pairing buffer that sits directly upstream of the radix-2 butterfly stage.
- Accepts a stream of N-lane complex vectors with a valid/ready handshake and groups consecutive vectors into pairs: first vector is operand 1, second is operand 2.
- Presents each completed pair as parallel din1/din2 arrays held stable for the butterfly.
- Two pair slots (ping-pong) let upstream fill one pair while downstream holds the other.

---
 rtl/bfly_in_buf_if.sv | 32 +++
 rtl/bfly_in_buf.sv | 116 +++++++++++
 tb/tb_bfly_in_buf.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bfly_in_buf_if.sv
// Handshake and data bundle between the upstream vector source, the pairing
// buffer and the radix-2 butterfly that consumes completed pairs.
interface bfly_in_buf_if #(
    parameter int N      = 16,
    parameter int IN_BIT = 14
);
    logic                     din_valid;
    logic                     din_ready;
    logic signed [IN_BIT-1:0] din_i   [0:N-1];
    logic signed [IN_BIT-1:0] din_q   [0:N-1];

    logic                     dout_valid;
    logic                     dout_ready;
    logic signed [IN_BIT-1:0] dout1_i [0:N-1];
    logic signed [IN_BIT-1:0] dout1_q [0:N-1];
    logic signed [IN_BIT-1:0] dout2_i [0:N-1];
    logic signed [IN_BIT-1:0] dout2_q [0:N-1];

    logic [7:0]               pair_cnt;

    // Environment side: drives vectors in and accepts pairs out.
    modport master (
        output din_valid, din_i, din_q, dout_ready,
        input  din_ready, dout_valid, dout1_i, dout1_q, dout2_i, dout2_q, pair_cnt
    );

    // Buffer side.
    modport slave (
        input  din_valid, din_i, din_q, dout_ready,
        output din_ready, dout_valid, dout1_i, dout1_q, dout2_i, dout2_q, pair_cnt
    );
endinterface

// File: rtl/bfly_in_buf.sv
// Ping-pong pairing buffer ahead of the radix-2 butterfly: consecutive input
// vectors become (vec1, vec2) pairs held stable on dout1/dout2 until consumed.
module bfly_in_buf #(
    parameter int N      = 16,
    parameter int IN_BIT = 14
) (
    input  logic         clk,
    input  logic         rstn,
    bfly_in_buf_if.slave bus
);

    localparam logic PH_VEC1 = 1'b0;
    localparam logic PH_VEC2 = 1'b1;

    logic [1:0] full_q,   full_d;
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic       phase_q,  phase_d;
    logic [7:0] cnt_q,    cnt_d;

    logic signed [IN_BIT-1:0] vec1_re_q [0:1][0:N-1];
    logic signed [IN_BIT-1:0] vec1_im_q [0:1][0:N-1];
    logic signed [IN_BIT-1:0] vec2_re_q [0:1][0:N-1];
    logic signed [IN_BIT-1:0] vec2_im_q [0:1][0:N-1];

    logic din_ready_w;
    logic dout_valid_w;
    logic accept;
    logic consume;

    // Both flags come straight from registers, so neither ready depends
    // combinationally on the opposite side's handshake input.
    assign din_ready_w  = ~full_q[wr_sel_q];
    assign dout_valid_w = full_q[rd_sel_q];
    assign accept       = bus.din_valid & din_ready_w;
    assign consume      = dout_valid_w & bus.dout_ready;

    assign bus.din_ready  = din_ready_w;
    assign bus.dout_valid = dout_valid_w;
    assign bus.pair_cnt   = cnt_q;

    // Accept writes an empty slot and consume frees a full one, so on a shared
    // cycle they always address different slots and can be applied together.
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;

        if (accept) begin
            if (phase_q == PH_VEC2) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
                phase_d          = PH_VEC1;
            end else begin
                phase_d          = PH_VEC2;
            end
        end

        if (consume) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
            cnt_d            = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            phase_q  <= PH_VEC1;
            cnt_q    <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned s = 0; s < 2; s++) begin
                for (int unsigned k = 0; k < N; k++) begin
                    vec1_re_q[s][k] <= '0;
                    vec1_im_q[s][k] <= '0;
                    vec2_re_q[s][k] <= '0;
                    vec2_im_q[s][k] <= '0;
                end
            end
        end else if (accept) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (phase_q == PH_VEC1) begin
                    vec1_re_q[wr_sel_q][k] <= bus.din_i[k];
                    vec1_im_q[wr_sel_q][k] <= bus.din_q[k];
                end else begin
                    vec2_re_q[wr_sel_q][k] <= bus.din_i[k];
                    vec2_im_q[wr_sel_q][k] <= bus.din_q[k];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            bus.dout1_i[k] = vec1_re_q[rd_sel_q][k];
            bus.dout1_q[k] = vec1_im_q[rd_sel_q][k];
            bus.dout2_i[k] = vec2_re_q[rd_sel_q][k];
            bus.dout2_q[k] = vec2_im_q[rd_sel_q][k];
        end
    end

endmodule

// File: tb/tb_bfly_in_buf.sv
// Bench for bfly_in_buf: scoreboard of expected pairs plus a cycle table for
// the backpressure / simultaneous accept-consume sequence.
module tb_bfly_in_buf;

    localparam int N      = 16;
    localparam int IN_BIT = 14;

    typedef logic signed [IN_BIT-1:0] lane_t;
    typedef struct packed {
        lane_t [N-1:0] i;
        lane_t [N-1:0] q;
    } vec_t;
    typedef struct packed {
        vec_t v1;
        vec_t v2;
    } pair_t;

    typedef struct {
        bit vld;
        int base;
        bit rdy;
        bit exp_drdy;
        bit exp_dval;
    } row_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bfly_in_buf_if #(.N(N), .IN_BIT(IN_BIT)) bus ();

    bfly_in_buf #(.N(N), .IN_BIT(IN_BIT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int         checks    = 0;
    int         errors    = 0;
    int         delivered = 0;
    pair_t      sb[$];
    vec_t       m_v1;
    bit         m_phase   = 1'b0;
    logic [7:0] exp_cnt   = '0;
    pair_t      held;
    bit         held_v    = 1'b0;

    function automatic vec_t mk(input int base);
        vec_t v;
        for (int k = 0; k < N; k++) begin
            v.i[k] = lane_t'(base + k);
            v.q[k] = lane_t'(-(base + k));
        end
        return v;
    endfunction

    function automatic vec_t mk_ext(input bit flip);
        vec_t v;
        for (int k = 0; k < N; k++) begin
            v.i[k] = ((k % 2) == int'(flip)) ? lane_t'(8191) : lane_t'(-8192);
            v.q[k] = ((k % 2) == int'(flip)) ? lane_t'(-8192) : lane_t'(8191);
        end
        return v;
    endfunction

    function automatic vec_t cur_in();
        vec_t v;
        for (int k = 0; k < N; k++) begin
            v.i[k] = bus.din_i[k];
            v.q[k] = bus.din_q[k];
        end
        return v;
    endfunction

    function automatic pair_t cur_out();
        pair_t p;
        for (int k = 0; k < N; k++) begin
            p.v1.i[k] = bus.dout1_i[k];
            p.v1.q[k] = bus.dout1_q[k];
            p.v2.i[k] = bus.dout2_i[k];
            p.v2.q[k] = bus.dout2_q[k];
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_pair(input string name, input pair_t act, input pair_t exp);
        int bad;
        checks++;
        if (act !== exp) begin
            errors++;
            bad = 0;
            for (int k = N - 1; k >= 0; k--)
                if (act.v1.i[k] !== exp.v1.i[k] || act.v1.q[k] !== exp.v1.q[k] ||
                    act.v2.i[k] !== exp.v2.i[k] || act.v2.q[k] !== exp.v2.q[k]) bad = k;
            $display("FAIL %s lane %0d: got v1=(%0d,%0d) v2=(%0d,%0d) expected v1=(%0d,%0d) v2=(%0d,%0d) at %0t",
                     name, bad, act.v1.i[bad], act.v1.q[bad], act.v2.i[bad], act.v2.q[bad],
                     exp.v1.i[bad], exp.v1.q[bad], exp.v2.i[bad], exp.v2.q[bad], $time);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        for (int k = 0; k < N; k++) begin
            bus.din_i[k] = v.i[k];
            bus.din_q[k] = v.q[k];
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v, output bit stalled);
        bit ok;
        stalled = 1'b0;
        ok      = 1'b0;
        drive_vec(v);
        bus.din_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.din_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            stalled = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got din_ready low for 64 cycles expected an accept at %0t", $time);
        end
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    // Scoreboard monitor: records accepts, checks pairs on consume, checks hold
    // stability and the pair counter every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_phase = 1'b0;
                sb.delete();
                exp_cnt = '0;
                held_v  = 1'b0;
            end else begin
                chk("pair_cnt", 32'(bus.pair_cnt), 32'(exp_cnt));
                if (bus.dout_valid === 1'b1) begin
                    if (held_v) cmp_pair("hold_stable", cur_out(), held);
                    if (bus.dout_ready === 1'b1) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_pair: got a consumed pair expected none pending at %0t", $time);
                        end else begin
                            cmp_pair("pair_data", cur_out(), sb.pop_front());
                        end
                        exp_cnt++;
                        delivered++;
                        held_v = 1'b0;
                    end else begin
                        held   = cur_out();
                        held_v = 1'b1;
                    end
                end else begin
                    held_v = 1'b0;
                end
                if (bus.din_valid === 1'b1 && bus.din_ready === 1'b1) begin
                    if (!m_phase) begin
                        m_v1    = cur_in();
                        m_phase = 1'b1;
                    end else begin
                        pair_t p;
                        p.v1 = m_v1;
                        p.v2 = cur_in();
                        sb.push_back(p);
                        m_phase = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected $finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        row_t tbl[11];
        bit   st;
        int   stalls;
        int   d0;

        // Both slots fill, stall, then drain with overlapping accept/consume.
        tbl[0]  = '{1, 1000, 0, 1, 0};
        tbl[1]  = '{1, 1001, 0, 1, 0};
        tbl[2]  = '{1, 1002, 0, 1, 1};
        tbl[3]  = '{1, 1003, 0, 1, 1};
        tbl[4]  = '{1, 1004, 0, 0, 1};
        tbl[5]  = '{1, 1004, 0, 0, 1};
        tbl[6]  = '{1, 1004, 1, 0, 1};
        tbl[7]  = '{1, 1004, 0, 1, 1};
        tbl[8]  = '{1, 1005, 1, 1, 1};
        tbl[9]  = '{0, 0,    1, 1, 1};
        tbl[10] = '{0, 0,    0, 1, 0};

        bus.din_valid  = 1'b1;
        bus.dout_ready = 1'b0;
        drive_vec(mk(77));
        rstn = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_din_ready", 32'(bus.din_ready), 1);
        chk("reset_dout_valid", 32'(bus.dout_valid), 0);
        chk("reset_pair_cnt", 32'(bus.pair_cnt), 0);
        cmp_pair("reset_dout", cur_out(), '0);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        rstn = 1'b1;

        // Single pair
        bus.dout_ready = 1'b1;
        send(mk(0), st);
        chk("single_not_yet_valid", 32'(bus.dout_valid), 0);
        send(mk(100), st);
        chk("single_valid", 32'(bus.dout_valid), 1);
        chk("single_dout1_i5", int'(bus.dout1_i[5]), 5);
        chk("single_dout2_q5", int'(bus.dout2_q[5]), -105);
        @(posedge clk);
        #1;
        chk("single_pair_cnt", 32'(bus.pair_cnt), 1);
        chk("single_drained", 32'(bus.dout_valid), 0);

        // Backpressure and simultaneous accept/consume
        for (int r = 0; r < 11; r++) begin
            @(posedge clk);
            #1;
            bus.din_valid  = tbl[r].vld;
            bus.dout_ready = tbl[r].rdy;
            if (tbl[r].vld) drive_vec(mk(tbl[r].base));
            @(negedge clk);
            chk($sformatf("bp_din_ready_r%0d", r), 32'(bus.din_ready), 32'(tbl[r].exp_drdy));
            chk($sformatf("bp_dout_valid_r%0d", r), 32'(bus.dout_valid), 32'(tbl[r].exp_dval));
        end
        @(posedge clk);
        #1;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        chk("bp_sb_empty", sb.size(), 0);
        chk("bp_pair_cnt", 32'(bus.pair_cnt), 4);

        // Full-rate stream with extremes
        bus.dout_ready = 1'b1;
        stalls = 0;
        d0 = delivered;
        for (int j = 0; j < 64; j++) begin
            send((j == 20 || j == 21) ? mk_ext(j[0]) : mk(j * 40 - 1280), st);
            if (st) stalls++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("full_no_stall", stalls, 0);
        chk("full_pairs", delivered - d0, 32);
        chk("full_sb_empty", sb.size(), 0);

        // Mid-pair reset
        bus.dout_ready = 1'b0;
        send(mk(5), st);
        rstn = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        send(mk(7), st);
        send(mk(9), st);
        chk("midrst_dout1_i0", int'(bus.dout1_i[0]), 7);
        chk("midrst_dout2_i0", int'(bus.dout2_i[0]), 9);
        bus.dout_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_pair_cnt", 32'(bus.pair_cnt), 1);

        // Counter wrap: 255 more pairs brings the count back to zero
        for (int j = 0; j < 510; j++) send(mk((j % 64) * 100 - 3200), st);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_wrap", 32'(bus.pair_cnt), 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
